uart_tx_queue: RTL

- Buffers ASCII bytes from the keyboard path (ScanCodeToAscii output, strobed by scan_code_ready) and feeds the UART transmitter (async_transmitter) one byte at a time.
- Sits between the PS/2 decode stage and the UART TX stage, replacing the direct start/data registers.
- Guarantees no byte is started while the transmitter is busy and no burst of keystrokes is lost up to DEPTH bytes.
- Optionally drops NUL codes produced for unmapped keys.

---
 rtl/uart_tx_queue_pkg.sv | 19 +
 rtl/uart_tx_queue_if.sv | 28 ++
 rtl/uart_tx_queue_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_queue.sv | 110 +++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared types and defaults for the keyboard-to-UART transmit queue.
package uart_tx_queue_pkg;

    localparam int UART_TX_QUEUE_DEPTH = 16;

    typedef logic [7:0] UartByte_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_IDLE
    } UartTxQueueState_t;

    // Occupancy needs one extra bit so that DEPTH entries is distinct from zero.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bundle of the producer, transmitter and status signals around the transmit queue.
interface uart_tx_queue_if
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = UART_TX_QUEUE_DEPTH
) ();

    logic                          pushValid;
    UartByte_t                     pushData;
    logic                          txBusy;
    logic                          txStart;
    UartByte_t                     txData;
    logic                          full;
    logic                          empty;
    logic [count_width(DEPTH)-1:0] count;
    logic                          overflow;

    modport master (
        output pushValid, pushData, txBusy,
        input  txStart, txData, full, empty, count, overflow
    );

    modport slave (
        input  pushValid, pushData, txBusy,
        output txStart, txData, full, empty, count, overflow
    );

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Single-clock FIFO with registered read port; strobes beyond full/empty are ignored.
module uart_tx_queue_sync_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = UART_TX_QUEUE_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  UartByte_t                     wr_data,
    input  logic                          pop,
    output UartByte_t                     rd_data,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    UartByte_t         mem [DEPTH];
    logic [AW-1:0]     wptr_reg;
    logic [AW-1:0]     rptr_reg;
    logic [CW-1:0]     count_reg;
    UartByte_t         rd_data_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg    <= '0;
            rptr_reg    <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rptr_reg    <= rptr_reg + 1'b1;
                rd_data_reg <= mem[rptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/uart_tx_queue.sv
// Queues keyboard ASCII bytes and hands them to the UART transmitter one at a time,
// never starting a byte while the transmitter reports busy.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH        = UART_TX_QUEUE_DEPTH,
    parameter int FILTER_NUL   = 1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_queue_if.slave bus
);

    localparam int CW = count_width(DEPTH);
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    UartTxQueueState_t state_reg;
    UartTxQueueState_t state_next;
    logic [TW-1:0]     timer_reg;
    logic [TW-1:0]     timer_next;
    logic              tx_start_reg;
    logic              overflow_reg;

    logic              is_nul;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    UartByte_t         fifo_rd_data;

    // Unmapped keys decode to NUL; dropping them here keeps them out of overflow too.
    assign is_nul   = (FILTER_NUL != 0) && (bus.pushData == 8'h00);
    assign push_req = bus.pushValid && !is_nul;
    assign push     = push_req && !fifo_full;

    uart_tx_queue_sync_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (bus.pushData),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (!fifo_empty && !bus.txBusy) begin
                    pop        = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            // A transmitter that never raises busy is assumed to have taken the byte.
            WAIT_BUSY: begin
                if (bus.txBusy) begin
                    state_next = WAIT_IDLE;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (!bus.txBusy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            tx_start_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            tx_start_reg <= pop;
            if (push_req && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.txStart  = tx_start_reg;
    assign bus.txData   = fifo_rd_data;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.overflow = overflow_reg;

endmodule
